word_packer: RTL

WORD_PACKER -- requirements
Module: word_packer

---
 rtl/word_packer.sv | 87 ++++++++
 1 files changed

// File: rtl/word_packer.sv
// Packs IN_W-bit lanes MSB-first into OUT_W-bit words with a one-deep output register.
// Optional partial-word flush is enabled by defining WORD_PACKER_FLUSH_EN.
module word_packer #(
    parameter  int IN_W  = 8,
    parameter  int LANES = 4,
    localparam int OUT_W = IN_W * LANES,
    localparam int CNT_W = $clog2(LANES)
) (
    input  logic             clk_4f,
    input  logic             reset_L,
    input  logic [IN_W-1:0]  data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             flush,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [CNT_W-1:0] lane_cnt,
    output logic [15:0]      word_cnt
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    logic [OUT_W-1:0] partial;
    logic [OUT_W-1:0] merged;
    logic [OUT_W-1:0] load_word;
    logic             slot_free;
    logic             last_lane;
    logic             accept;
    logic             handshake;
    logic             flush_take;
    logic             load;

    assign slot_free = !valid_out || ready_in;
    assign last_lane = (lane_cnt == LAST_LANE);
    assign ready_out = !(last_lane && !slot_free);
    assign accept    = valid_in && ready_out;
    assign handshake = valid_out && ready_in;

    always_comb begin
        merged = partial;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_cnt == CNT_W'(k))
                merged[OUT_W-1-k*IN_W -: IN_W] = data_in;
        end
    end

    assign load_word = accept ? merged : partial;

`ifdef WORD_PACKER_FLUSH_EN
    // A lane arriving with flush joins the flushed word; the final lane takes the normal path.
    assign flush_take = flush && slot_free && (lane_cnt != '0 || accept) && !(accept && last_lane);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_take   = 1'b0;
`endif

    assign load = (accept && last_lane) || flush_take;

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_cnt  <= '0;
            word_cnt  <= '0;
            partial   <= '0;
        end else begin
            if (load) begin
                data_out  <= load_word;
                valid_out <= 1'b1;
                partial   <= '0;
                lane_cnt  <= '0;
            end else begin
                if (accept) begin
                    partial  <= merged;
                    lane_cnt <= lane_cnt + CNT_W'(1);
                end
                if (handshake)
                    valid_out <= 1'b0;
            end
            if (handshake)
                word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule
